// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared Rijndael definitions for the round datapath.
//   aes_byte_t        8-bit state byte
//   NB_128/192/256    legal state column counts
//   shift_offset()    ShiftRows row offset for a given NB and row
//   nb_is_legal()     elaboration-time NB check
//   byte_parity()     even-parity bit of one state byte
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [7:0] aes_byte_t;

  localparam int NB_128 = 4;
  localparam int NB_192 = 6;
  localparam int NB_256 = 8;

  // Rijndael row offsets: 0,1,2,3 for 128/192-bit blocks and 0,1,3,4 for
  // 256-bit blocks, where rows 2 and 3 skip one column further.
  function automatic int shift_offset(input int nb, input int row);
    if (nb == NB_256 && row >= 2) begin
      return row + 1;
    end
    return row;
  endfunction

  function automatic bit nb_is_legal(input int nb);
    return (nb == NB_128) || (nb == NB_192) || (nb == NB_256);
  endfunction

  // Even parity: the returned bit makes the byte plus parity even.
  function automatic logic byte_parity(input aes_byte_t b);
    return ^b;
  endfunction

endpackage

// File: rtl/rijndael_shift_rows_perm.sv
// ---------------------------------------------------------------------------
// rijndael_shift_rows_perm
// Purely combinational ShiftRows / InvShiftRows byte permutation.
// Byte k of the state sits at data[DW-1-8k -: 8]; row = k mod 4 and
// column = k div 4.
// Ports:
//   data       in   DW   input state
//   inv        in   1    0 = forward ShiftRows, 1 = InvShiftRows
//   perm_data  out  DW   permuted state, same byte layout
// ---------------------------------------------------------------------------
module rijndael_shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] data,
  input  logic             inv,
  output logic [32*NB-1:0] perm_data
);

  localparam int DW = 32*NB;

  logic [DW-1:0] fwd;
  logic [DW-1:0] bwd;

  // Both directions are pure wiring; only the final select costs logic.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int OFF   = shift_offset(NB, r);
      localparam int DST   = r + 4*c;
      localparam int SRC_F = r + 4*((c + OFF) % NB);
      localparam int SRC_I = r + 4*((c - OFF + NB) % NB);
      assign fwd[DW-1-8*DST -: 8] = data[DW-1-8*SRC_F -: 8];
      assign bwd[DW-1-8*DST -: 8] = data[DW-1-8*SRC_I -: 8];
    end
  end

  assign perm_data = inv ? bwd : fwd;

endmodule

// File: rtl/rijndael_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// rijndael_shift_rows_pipe
// Elastic, pipelined ShiftRows / InvShiftRows unit for NB = 4, 6 or 8
// (128/192/256-bit blocks). The permutation is applied combinationally on
// acceptance and the result is carried through PIPE_DEPTH valid/data/tag
// stages with collapsing bubbles.
// Optional feature macro: SHIFTROWS_PARITY_EN adds per-byte even parity
// carried with the data and the sticky par_err output.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      input beat present
//   in_ready   out  1      input beat accepted this cycle if in_valid
//   in_data    in   DW     input state
//   in_inv     in   1      0 = ShiftRows, 1 = InvShiftRows (per beat)
//   in_tag     in   TAG_W  sideband carried with the beat
//   out_valid  out  1      output beat present
//   out_ready  in   1      downstream accepts the beat
//   out_data   out  DW     permuted state
//   out_tag    out  TAG_W  tag of the output beat
//   par_err    out  1      sticky parity error (SHIFTROWS_PARITY_EN only)
// ---------------------------------------------------------------------------
module rijndael_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB         = 4,
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32*NB-1:0] in_data,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32*NB-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef SHIFTROWS_PARITY_EN
  ,
  output logic             par_err
`endif
);

  localparam int DW     = 32*NB;
  localparam int NBYTES = 4*NB;
  localparam int LAST   = PIPE_DEPTH - 1;

  if (!nb_is_legal(NB)) begin : g_bad_nb
    $error("rijndael_shift_rows_pipe: NB must be 4, 6 or 8");
  end

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
    $error("rijndael_shift_rows_pipe: PIPE_DEPTH must be in 1..4");
  end

  logic [DW-1:0]         perm_data;
  logic [PIPE_DEPTH-1:0] stg_v;
  logic [PIPE_DEPTH-1:0] go;
  logic [DW-1:0]         stg_data [PIPE_DEPTH];
  logic [TAG_W-1:0]      stg_tag  [PIPE_DEPTH];

  rijndael_shift_rows_perm #(.NB(NB)) u_perm (
    .data      (in_data),
    .inv       (in_inv),
    .perm_data (perm_data)
  );

`ifdef SHIFTROWS_PARITY_EN
  logic [NBYTES-1:0] stg_par [PIPE_DEPTH];
  logic [DW-1:0]     par_spread;
  logic [DW-1:0]     par_spread_perm;
  logic [NBYTES-1:0] in_par;
  logic [NBYTES-1:0] out_par;

  // Each parity bit is parked in the LSB of a byte-sized slot so that the
  // same permutation block moves it exactly like its data byte.
  always_comb begin
    par_spread = '0;
    for (int k = 0; k < NBYTES; k++) begin
      par_spread[DW-8-8*k] = byte_parity(in_data[DW-1-8*k -: 8]);
    end
  end

  rijndael_shift_rows_perm #(.NB(NB)) u_par_perm (
    .data      (par_spread),
    .inv       (in_inv),
    .perm_data (par_spread_perm)
  );

  // Only the slot LSB can be set, so reducing the whole slot is equivalent.
  always_comb begin
    in_par = '0;
    for (int k = 0; k < NBYTES; k++) begin
      in_par[k] = ^par_spread_perm[DW-1-8*k -: 8];
    end
  end

  always_comb begin
    out_par = '0;
    for (int k = 0; k < NBYTES; k++) begin
      out_par[k] = byte_parity(out_data[DW-1-8*k -: 8]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err <= 1'b0;
    end else if (out_valid && out_ready && (out_par != stg_par[LAST])) begin
      par_err <= 1'b1;
    end
  end
`endif

  // Stage i may load when the output is being taken or any stage from i to
  // the end is empty; this is the unrolled ready chain, so bubbles collapse.
  for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_go
    assign go[i] = out_ready || !(&stg_v[LAST:i]);
  end

  for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stg
    logic             v;
    logic [DW-1:0]    data;
    logic [TAG_W-1:0] tag;
    logic             nxt_v;
    logic [DW-1:0]    nxt_data;
    logic [TAG_W-1:0] nxt_tag;
`ifdef SHIFTROWS_PARITY_EN
    logic [NBYTES-1:0] par;
    logic [NBYTES-1:0] nxt_par;
`endif

    if (i == 0) begin : g_head
      assign nxt_v    = in_valid;
      assign nxt_data = perm_data;
      assign nxt_tag  = in_tag;
`ifdef SHIFTROWS_PARITY_EN
      assign nxt_par  = in_par;
`endif
    end else begin : g_body
      assign nxt_v    = stg_v[i-1];
      assign nxt_data = stg_data[i-1];
      assign nxt_tag  = stg_tag[i-1];
`ifdef SHIFTROWS_PARITY_EN
      assign nxt_par  = stg_par[i-1];
`endif
    end

    // Payload only moves with a valid beat, which keeps a stalled or empty
    // stage's data untouched.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v    <= 1'b0;
        data <= '0;
        tag  <= '0;
`ifdef SHIFTROWS_PARITY_EN
        par  <= '0;
`endif
      end else if (go[i]) begin
        v <= nxt_v;
        if (nxt_v) begin
          data <= nxt_data;
          tag  <= nxt_tag;
`ifdef SHIFTROWS_PARITY_EN
          par  <= nxt_par;
`endif
        end
      end
    end

    assign stg_v[i]    = v;
    assign stg_data[i] = data;
    assign stg_tag[i]  = tag;
`ifdef SHIFTROWS_PARITY_EN
    assign stg_par[i]  = par;
`endif
  end

  assign in_ready  = go[0];
  assign out_valid = stg_v[LAST];
  assign out_data  = stg_data[LAST];
  assign out_tag   = stg_tag[LAST];

endmodule

// File: tb/tb_rijndael_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// tb_rijndael_shift_rows_pipe
// Self-checking bench: one NB=4/PIPE_DEPTH=2 instance and one
// NB=8/PIPE_DEPTH=3 instance. Expected beats are queued on acceptance and
// compared when each instance emits an output transfer.
// Optional macro SHIFTROWS_PARITY_EN enables the parity fault-injection step.
// ---------------------------------------------------------------------------
module tb_rijndael_shift_rows_pipe;

  localparam int D4 = 2;
  localparam int D8 = 3;

  typedef struct packed {
    logic [255:0] data;
    logic [3:0]   tag;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         i4_valid, i4_ready, i4_inv, o4_valid, o4_ready;
  logic [127:0] i4_data, o4_data;
  logic [3:0]   i4_tag, o4_tag;
  logic         i8_valid, i8_ready, i8_inv, o8_valid, o8_ready;
  logic [255:0] i8_data, o8_data;
  logic [3:0]   i8_tag, o8_tag;
`ifdef SHIFTROWS_PARITY_EN
  logic         par4, par8;
`endif

  int passed   = 0;
  int checks   = 0;
  int cyc      = 0;
  int stall_lo = -1;
  int stall_hi = -2;
  exp_t q4[$];
  exp_t q8[$];

  logic         h4_valid = 1'b0;
  logic [127:0] h4_data  = '0;
  logic [3:0]   h4_tag   = '0;
  int           stall4   = 0;

  rijndael_shift_rows_pipe #(.NB(4), .PIPE_DEPTH(D4), .TAG_W(4)) u4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (i4_valid),
    .in_ready  (i4_ready),
    .in_data   (i4_data),
    .in_inv    (i4_inv),
    .in_tag    (i4_tag),
    .out_valid (o4_valid),
    .out_ready (o4_ready),
    .out_data  (o4_data),
    .out_tag   (o4_tag)
`ifdef SHIFTROWS_PARITY_EN
    ,
    .par_err   (par4)
`endif
  );

  rijndael_shift_rows_pipe #(.NB(8), .PIPE_DEPTH(D8), .TAG_W(4)) u8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (i8_valid),
    .in_ready  (i8_ready),
    .in_data   (i8_data),
    .in_inv    (i8_inv),
    .in_tag    (i8_tag),
    .out_valid (o8_valid),
    .out_ready (o8_ready),
    .out_data  (o8_data),
    .out_tag   (o8_tag)
`ifdef SHIFTROWS_PARITY_EN
    ,
    .par_err   (par8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Reference ShiftRows written directly from the row/column definition.
  function automatic logic [255:0] model(input int nb, input logic [255:0] d, input logic inv);
    logic [255:0] o;
    int offs[4];
    int w;
    int src;
    if (nb == 8) begin
      offs[0] = 0; offs[1] = 1; offs[2] = 3; offs[3] = 4;
    end else begin
      offs[0] = 0; offs[1] = 1; offs[2] = 2; offs[3] = 3;
    end
    o = '0;
    w = 32*nb;
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - offs[r] + nb) % nb) : ((c + offs[r]) % nb);
        o[w-1-8*(r+4*c) -: 8] = d[w-1-8*(r+4*src) -: 8];
      end
    end
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    o4_ready = !(cyc >= stall_lo && cyc <= stall_hi);
  endtask

  task automatic idle();
    i4_valid = 1'b0;
    i8_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int sel, input logic [255:0] data, input logic inv,
                               input logic [3:0] tag, input logic [255:0] exp);
    exp_t e;
    bit   ok;
    ok     = 1'b0;
    e.data = exp;
    e.tag  = tag;
    if (sel == 4) begin
      i4_valid = 1'b1; i4_data = data[127:0]; i4_inv = inv; i4_tag = tag;
    end else begin
      i8_valid = 1'b1; i8_data = data; i8_inv = inv; i8_tag = tag;
    end
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((sel == 4) ? i4_ready : i8_ready) begin
        if (sel == 4) q4.push_back(e);
        else q8.push_back(e);
        ok = 1'b1;
      end
      tick();
      if (ok) break;
    end
    checks++;
    assert (ok) passed++;
    else $error("[TB] FAIL accept_timeout sel=%0d observed=not_accepted expected=accepted", sel);
  endtask

  task automatic checkLatency(input int sel, input int depth);
    for (int k = 1; k < depth; k++) begin
      @(negedge clk);
      checkOutput("latency_early", 256'((sel == 4) ? o4_valid : o8_valid), 256'd0);
      tick();
    end
    @(negedge clk);
    checkOutput("latency_arrive", 256'((sel == 4) ? o4_valid : o8_valid), 256'd1);
    tick();
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (q4.size() == 0 && q8.size() == 0 && !o4_valid && !o8_valid) break;
      tick();
    end
    checks++;
    assert (q4.size() == 0 && q8.size() == 0) passed++;
    else $error("[TB] FAIL drain observed=%0d/%0d pending expected=0/0", q4.size(), q8.size());
  endtask

  // Scoreboard, hold-stability and full-pipeline checks for the NB=4 unit.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      h4_valid = 1'b0;
      stall4   = 0;
    end else begin
      if (h4_valid) begin
        checkOutput("u4_hold_data", 256'(o4_data), 256'(h4_data));
        checkOutput("u4_hold_tag", 256'(o4_tag), 256'(h4_tag));
      end
      if (o4_valid && o4_ready) begin
        if (q4.size() == 0) begin
          checkOutput("u4_spurious_valid", 256'(o4_valid), 256'd0);
        end else begin
          e = q4.pop_front();
          checkOutput("u4_data", 256'(o4_data), e.data);
          checkOutput("u4_tag", 256'(o4_tag), 256'(e.tag));
        end
      end
      if (!o4_ready && i4_valid) stall4++;
      else stall4 = 0;
      if (stall4 > D4) checkOutput("u4_in_ready_full", 256'(i4_ready), 256'd0);
      h4_valid = o4_valid && !o4_ready;
      h4_data  = o4_data;
      h4_tag   = o4_tag;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && o8_valid && o8_ready) begin
      if (q8.size() == 0) begin
        checkOutput("u8_spurious_valid", 256'(o8_valid), 256'd0);
      end else begin
        e = q8.pop_front();
        checkOutput("u8_data", o8_data, e.data);
        checkOutput("u8_tag", 256'(o8_tag), 256'(e.tag));
      end
    end
  end

  initial begin
    logic [255:0] d;
    logic [255:0] f;
    logic [255:0] pat4;
    logic [255:0] pat8;
    logic [255:0] exp8;

    pat4 = 256'h000102030405060708090a0b0c0d0e0f;
    pat8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    exp8 = 256'h00050e13040912170_80d161b0c111a1f10151e0314190207181d060b1c010a0f >> 4;
    exp8 = 256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

    rst = 1'b1;
    i4_valid = 1'b0; i4_data = '0; i4_inv = 1'b0; i4_tag = '0;
    i8_valid = 1'b0; i8_data = '0; i8_inv = 1'b0; i8_tag = '0;
    o4_ready = 1'b1; o8_ready = 1'b1;

    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_u4_out_valid", 256'(o4_valid), 256'd0);
    checkOutput("rst_u4_out_data", 256'(o4_data), 256'd0);
    checkOutput("rst_u4_out_tag", 256'(o4_tag), 256'd0);
    checkOutput("rst_u8_out_valid", 256'(o8_valid), 256'd0);
    checkOutput("rst_u8_out_data", o8_data, 256'd0);
    checkOutput("rst_u8_out_tag", 256'(o8_tag), 256'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_u4_in_ready", 256'(i4_ready), 256'd1);
    checkOutput("rst_u8_in_ready", 256'(i8_ready), 256'd1);
    tick();

    $display("[TB] NB=4 directed vectors");
    applyStimulus(4, pat4, 1'b0, 4'd1, 256'h00050a0f04090e03080d02070c01060b);
    idle();
    checkLatency(4, D4);
    applyStimulus(4, pat4, 1'b1, 4'd2, 256'h000d0a0704010e0b0805020f0c090603);
    applyStimulus(4, 256'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'd3,
                  256'hd4bf5d30e0b452aeb84111f11e2798e5);
    idle();
    drain();

    $display("[TB] NB=8 vectors and round trip");
    applyStimulus(8, pat8, 1'b0, 4'd4, exp8);
    idle();
    checkLatency(8, D8);
    d = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    f = model(8, d, 1'b0);
    applyStimulus(8, d, 1'b0, 4'd5, f);
    applyStimulus(8, f, 1'b1, 4'd6, d);
    applyStimulus(8, exp8, 1'b1, 4'd7, pat8);
    idle();
    drain();

    $display("[TB] back-to-back beats with output stall");
    stall_lo = cyc + 5;
    stall_hi = cyc + 14;
    for (int i = 0; i < 20; i++) begin
      d = '0;
      d[127:0] = {$urandom(), $urandom(), $urandom(), $urandom()};
      applyStimulus(4, d, 1'(i % 2), 4'(i % 16), model(4, d, 1'(i % 2)));
    end
    idle();
    drain();
    stall_lo = -1;
    stall_hi = -2;

    $display("[TB] reset with beats in flight");
    d = '0;
    d[127:0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(4, d, 1'b0, 4'd10, model(4, d, 1'b0));
    applyStimulus(4, pat4, 1'b1, 4'd11, model(4, pat4, 1'b1));
    rst = 1'b1;
    idle();
    q4.delete();
    @(negedge clk);
    checkOutput("midrst_out_valid", 256'(o4_valid), 256'd0);
    checkOutput("midrst_out_data", 256'(o4_data), 256'd0);
    checkOutput("midrst_out_tag", 256'(o4_tag), 256'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_in_ready", 256'(i4_ready), 256'd1);
    checkOutput("postrst_out_valid", 256'(o4_valid), 256'd0);
    tick();
    applyStimulus(4, pat4, 1'b0, 4'd12, 256'h00050a0f04090e03080d02070c01060b);
    idle();
    checkLatency(4, D4);
    drain();

`ifdef SHIFTROWS_PARITY_EN
    $display("[TB] parity error injection");
    checkOutput("par_err_init", 256'(par4), 256'd0);
    d = '0;
    d[127:0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    f = model(4, d, 1'b0) ^ 256'd1;
    applyStimulus(4, d, 1'b0, 4'd9, f);
    idle();
    force u4.g_stg[0].data = f[127:0];
    tick();
    release u4.g_stg[0].data;
    tick();
    @(negedge clk);
    checkOutput("par_err_set", 256'(par4), 256'd1);
    tick();
    applyStimulus(4, pat4, 1'b1, 4'd13, 256'h000d0a0704010e0b0805020f0c090603);
    idle();
    drain();
    @(negedge clk);
    checkOutput("par_err_sticky", 256'(par4), 256'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("par_err_clear", 256'(par4), 256'd0);
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
